// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save accumulator.
package csa_pkg;
    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/ripple_carry_4_bit.sv
// 4-bit ripple-carry adder used to resolve one chunk of the redundant total.
module ripple_carry_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    assign cout = c[4];
endmodule

// File: rtl/csa_accumulator.sv
// Accumulates a packet of operands in carry-save form, then resolves the
// redundant total one 4-bit chunk per cycle through a single ripple adder.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [W+CNT_W-1:0]   out_sum,
    output logic [CNT_W:0]       out_count,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int ACC_W  = W + CNT_W;
    localparam int NCHUNK = ACC_W / CHUNK_W;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W:0] CNT_LIM = (CNT_W+1)'(1) << CNT_W;
    localparam logic [KW-1:0]  K_LAST  = KW'(NCHUNK - 1);

    if (ACC_W % CHUNK_W != 0) begin : g_bad_width
        $error("csa_accumulator: W+CNT_W must be a multiple of 4");
    end

    state_t             state;
    logic [ACC_W-1:0]   s_q, c_q, result;
    logic [CNT_W:0]     count;
    logic               ovf;
    logic [KW-1:0]      k;
    logic               cy;

    logic               accept;
    logic [ACC_W-1:0]   x, s_nxt, maj;
    logic [CHUNK_W-1:0] ch_sum;
    logic               ch_cout;

    assign accept = in_valid && (state == ACCUM);

    // 3:2 compression: no carry chain, only per-bit logic.
    assign x     = ACC_W'(in_data);
    assign s_nxt = s_q ^ c_q ^ x;
    assign maj   = (s_q & c_q) | (s_q & x) | (c_q & x);

    ripple_carry_4_bit u_chunk_add (
        .a    (s_q[int'(k)*CHUNK_W +: CHUNK_W]),
        .b    (c_q[int'(k)*CHUNK_W +: CHUNK_W]),
        .cin  (cy),
        .sum  (ch_sum),
        .cout (ch_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ACCUM;
            s_q    <= '0;
            c_q    <= '0;
            result <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            k      <= '0;
            cy     <= 1'b0;
        end else begin
            case (state)
                ACCUM: if (accept) begin
                    s_q   <= s_nxt;
                    c_q   <= {maj[ACC_W-2:0], 1'b0};
                    count <= (count == '1) ? count : count + 1'b1;
                    // count >= limit before this accept means it ends above the limit
                    if (count >= CNT_LIM) ovf <= 1'b1;
                    if (in_last) begin
                        state <= RESOLVE;
                        k     <= '0;
                        cy    <= 1'b0;
                    end
                end
                RESOLVE: begin
                    result[int'(k)*CHUNK_W +: CHUNK_W] <= ch_sum;
                    cy <= ch_cout;
                    k  <= k + 1'b1;
                    if (k == K_LAST) state <= DONE;
                end
                DONE: if (out_ready) begin
                    state <= ACCUM;
                    s_q   <= '0;
                    c_q   <= '0;
                    count <= '0;
                    ovf   <= 1'b0;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = result;
    assign out_count = count;
    assign out_ovf   = ovf;
endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: a packet-level model checked every cycle
// plus literal expectations for each scenario.
module tb_csa_accumulator;
    localparam int W = 4, CNT_W = 4, ACC_W = 8, NCHUNK = 2;

    logic             clk = 0, rst = 1;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 0, in_last = 0, out_ready = 0;
    logic             in_ready, out_ovf, out_valid;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W:0]   out_count;

    int checks = 0, errors = 0;
    bit go = 0;

    csa_accumulator #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: plain integer sum and count, plus a latency countdown.
    int  m_acc, m_cnt, m_wait, m_sum, m_rcnt;
    bit  m_ready = 1, m_valid = 0, m_ovf, m_rovf;

    always @(posedge clk) begin
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_wait = 0;
            m_ready = 1; m_valid = 0;
        end else if (m_ready) begin
            if (in_valid) begin
                m_acc += in_data;
                m_cnt++;
                if (m_cnt > (1 << CNT_W)) m_ovf = 1;
                if (in_last) begin
                    m_ready = 0; m_wait = NCHUNK;
                    m_sum = m_acc % (1 << ACC_W);
                    m_rcnt = (m_cnt > 31) ? 31 : m_cnt;
                    m_rovf = m_ovf;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0; m_ready = 1;
            m_acc = 0; m_cnt = 0; m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_count", out_count, m_rcnt);
                chk("out_ovf", out_ovf, m_rovf);
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input bit last);
        in_valid = 1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic send_n(input logic [W-1:0] d, input int n);
        for (int i = 0; i < n; i++) send(d, i == n - 1);
    endtask

    // Returns number of edges after the last accept until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) return;
            @(posedge clk); #1;
            lat++;
        end
        chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        chk("in_ready_after_hs", in_ready, 1);
    endtask

    int lat;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0; go = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);

        // four 0xF
        send_n(4'hF, 4);
        wait_valid(lat);
        chk("lat4", lat, 2);
        chk("sum4", out_sum, 8'h3C);
        chk("cnt4", out_count, 4);
        chk("ovf4", out_ovf, 0);
        handshake();

        // sixteen 0xF: at the count limit, no overflow
        send_n(4'hF, 16);
        wait_valid(lat);
        chk("sum16", out_sum, 8'hF0);
        chk("cnt16", out_count, 16);
        chk("ovf16", out_ovf, 0);
        handshake();

        // seventeen 0xF: one past the limit
        send_n(4'hF, 17);
        wait_valid(lat);
        chk("sum17", out_sum, 8'hFF);
        chk("cnt17", out_count, 17);
        chk("ovf17", out_ovf, 1);
        handshake();

        // single operand with in_valid held high throughout
        in_valid = 1; in_data = 4'h7; in_last = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_ready_low", in_ready, 0);
        wait_valid(lat);
        chk("sum_single", out_sum, 8'h07);
        chk("cnt_single", out_count, 1);
        in_valid = 0; in_last = 0;
        handshake();

        // held result under back-pressure
        send_n(4'hF, 4);
        wait_valid(lat);
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_sum", out_sum, 8'h3C);
            chk("hold_ready", in_ready, 0);
        end
        handshake();
        send(4'h1, 0); send(4'h2, 1);
        wait_valid(lat);
        chk("sum_1_2", out_sum, 8'h03);
        handshake();

        // all-zero packet
        send_n(4'h0, 3);
        wait_valid(lat);
        chk("sum_zero", out_sum, 8'h00);
        chk("cnt_zero", out_count, 3);
        handshake();

        // reset during the first resolve cycle abandons the packet
        send(4'h9, 0); send(4'h4, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_valid", out_valid, 0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_valid", out_valid, 0);
        end
        send(4'h3, 0); send(4'h5, 1);
        wait_valid(lat);
        chk("sum_3_5", out_sum, 8'h08);
        chk("cnt_3_5", out_count, 2);
        handshake();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
